alu_arbiter: RTL and testbench

//  - Shares one combinational alu instance between N_REQ requesters (e.g. execute stage, branch/address unit).
//  - Each requester has a valid/ready request channel and a valid/ready response channel.
//  - The block arbitrates, latches operands, registers the ALU result and returns it to the winning requester.

---
 rtl/alu_arbiter_pkg.sv | 40 ++++
 rtl/alu_arbiter_alu.sv | 34 +++
 rtl/alu_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encodings and the
// {funct3,funct7} op-code constants understood by the shared ALU.
package alu_arbiter_pkg;

    localparam int CID_W  = 10;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ALU_ARB_IDLE = 2'd0,
        ALU_ARB_EXEC = 2'd1,
        ALU_ARB_RESP = 2'd2
    } arb_state_t;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SLT     = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b000_0000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b010_0000;

    // Full op codes as seen on req_cid_in: {funct3, funct7}.
    localparam logic [CID_W-1:0] CID_ADD  = {FUNCT3_ADD_SUB, FUNCT7_BASE};
    localparam logic [CID_W-1:0] CID_SUB  = {FUNCT3_ADD_SUB, FUNCT7_ALT};
    localparam logic [CID_W-1:0] CID_SLL  = {FUNCT3_SLL,     FUNCT7_BASE};
    localparam logic [CID_W-1:0] CID_SLT  = {FUNCT3_SLT,     FUNCT7_BASE};
    localparam logic [CID_W-1:0] CID_SLTU = {FUNCT3_SLTU,    FUNCT7_BASE};
    localparam logic [CID_W-1:0] CID_XOR  = {FUNCT3_XOR,     FUNCT7_BASE};
    localparam logic [CID_W-1:0] CID_SRL  = {FUNCT3_SRL_SRA, FUNCT7_BASE};
    localparam logic [CID_W-1:0] CID_SRA  = {FUNCT3_SRL_SRA, FUNCT7_ALT};
    localparam logic [CID_W-1:0] CID_OR   = {FUNCT3_OR,      FUNCT7_BASE};
    localparam logic [CID_W-1:0] CID_AND  = {FUNCT3_AND,     FUNCT7_BASE};

    localparam logic [DATA_W-1:0] ALU_INVALID = 32'hFFFF_FFFF;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational integer ALU shared by all requesters of alu_arbiter.
// Unknown op codes return all ones.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [CID_W-1:0]  cid,
    input  logic [DATA_W-1:0] arg1,
    input  logic [DATA_W-1:0] arg2,
    output logic [DATA_W-1:0] result
);

    logic [4:0] shamt;

    assign shamt = arg2[4:0];

    always_comb begin
        // NOTE: result gets a default before the case so no path leaves it unassigned and infers a latch.
        result = ALU_INVALID;
        case (cid)
            CID_ADD:  result = arg1 + arg2;
            CID_SUB:  result = arg1 - arg2;
            CID_SLL:  result = arg1 << shamt;
            CID_SLT:  result = {31'd0, $signed(arg1) < $signed(arg2)};
            CID_SLTU: result = {31'd0, arg1 < arg2};
            CID_XOR:  result = arg1 ^ arg2;
            CID_SRL:  result = arg1 >> shamt;
            CID_SRA:  result = $signed(arg1) >>> shamt;
            CID_OR:   result = arg1 | arg2;
            CID_AND:  result = arg1 & arg2;
            default:  result = ALU_INVALID;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ valid/ready requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                    clk_in,
    input  logic                    nrst_in,
    input  logic [N_REQ-1:0]        req_valid_in,
    output logic [N_REQ-1:0]        req_ready_out,
    input  logic [CID_W*N_REQ-1:0]  req_cid_in,
    input  logic [DATA_W*N_REQ-1:0] req_arg1_in,
    input  logic [DATA_W*N_REQ-1:0] req_arg2_in,
    output logic [N_REQ-1:0]        rsp_valid_out,
    input  logic [N_REQ-1:0]        rsp_ready_in,
    output logic [DATA_W-1:0]       rsp_data_out,
    output logic                    busy_out
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    arb_state_t        state;
    logic [CID_W-1:0]  cid_q;
    logic [DATA_W-1:0] arg1_q;
    logic [DATA_W-1:0] arg2_q;
    logic [IDX_W-1:0]  owner_q;
    logic [IDX_W-1:0]  search_start;
    logic [IDX_W-1:0]  winner;
    logic              req_fire;
    logic [DATA_W-1:0] alu_result;

    // First valid requester found scanning upward from start, wrapping at N_REQ.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] valid,
                                                     input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] cand;
        logic             found;
        win   = start;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((32'(start) + 32'(i)) % 32'(N_REQ));
            if (!found && valid[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign winner        = pick_winner(req_valid_in, search_start);
    assign req_fire      = (state == ALU_ARB_IDLE) && (|req_valid_in);
    assign req_ready_out = req_fire ? (ONE << winner) : '0;
    assign busy_out      = (state != ALU_ARB_IDLE);

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] grant_ptr;

    // Pointer holds the index searched first; it moves past the winner on every grant.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            grant_ptr <= '0;
        end else if (req_fire) begin
            grant_ptr <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    assign search_start = grant_ptr;
`else
    assign search_start = '0;
`endif

    alu_arbiter_alu u_alu (
        .cid    (cid_q),
        .arg1   (arg1_q),
        .arg2   (arg2_q),
        .result (alu_result)
    );

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            // NOTE: operand and owner registers are reset too, so a discarded op leaves no stale state behind.
            state         <= ALU_ARB_IDLE;
            cid_q         <= '0;
            arg1_q        <= '0;
            arg2_q        <= '0;
            owner_q       <= '0;
            rsp_valid_out <= '0;
            rsp_data_out  <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                ALU_ARB_IDLE: begin
                    if (req_fire) begin
                        cid_q   <= req_cid_in[CID_W*winner +: CID_W];
                        arg1_q  <= req_arg1_in[DATA_W*winner +: DATA_W];
                        arg2_q  <= req_arg2_in[DATA_W*winner +: DATA_W];
                        owner_q <= winner;
                        state   <= ALU_ARB_EXEC;
                    end
                end
                ALU_ARB_EXEC: begin
                    rsp_data_out  <= alu_result;
                    rsp_valid_out <= ONE << owner_q;
                    state         <= ALU_ARB_RESP;
                end
                ALU_ARB_RESP: begin
                    if (rsp_ready_in[owner_q]) begin
                        rsp_valid_out <= '0;
                        state         <= ALU_ARB_IDLE;
                    end
                end
                default: begin
                    rsp_valid_out <= '0;
                    state         <= ALU_ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter (N_REQ=2); expected grant
// order follows ALU_ARB_ROUND_ROBIN_EN when it is defined.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N = 2;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [10*N-1:0] req_cid = '0;
    logic [32*N-1:0] req_arg1 = '0;
    logic [32*N-1:0] req_arg2 = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [31:0]     rsp_data;
    logic            busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        r;
        logic [9:0]  cid;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(N)) dut (
        .clk_in        (clk),
        .nrst_in       (nrst),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready),
        .req_cid_in    (req_cid),
        .req_arg1_in   (req_arg1),
        .req_arg2_in   (req_arg2),
        .rsp_valid_out (rsp_valid),
        .rsp_ready_in  (rsp_ready),
        .rsp_data_out  (rsp_data),
        .busy_out      (busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [9:0] cid, input logic [31:0] a1, input logic [31:0] a2);
        req_cid[10*r +: 10]  = cid;
        req_arg1[32*r +: 32] = a1;
        req_arg2[32*r +: 32] = a2;
    endtask

    // Bounded wait until any req_ready bit is high.
    task automatic wait_ready();
        int n;
        n = 0;
        #1;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // One complete transaction from requester r, checking every phase.
    task automatic run_op(input string nm, input int r, input logic [9:0] cid,
                          input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] exp);
        set_req(r, cid, a1, a2);
        req_valid[r] = 1'b1;
        wait_ready();
        check({nm, " ready"}, 32'(req_ready), 32'(1) << r);
        tick();
        req_valid[r] = 1'b0;
        check({nm, " exec busy"}, 32'(busy), 32'd1);
        check({nm, " exec no rsp"}, 32'(rsp_valid), 32'd0);
        tick();
        check({nm, " rsp valid"}, 32'(rsp_valid), 32'(1) << r);
        check({nm, " rsp data"}, rsp_data, exp);
        check({nm, " resp ready low"}, 32'(req_ready), 32'd0);
        rsp_ready[r] = 1'b1;
        tick();
        rsp_ready[r] = 1'b0;
        check({nm, " idle busy"}, 32'(busy), 32'd0);
        check({nm, " idle rsp"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, CID_ADD,  32'd5,          32'd7,          32'd12};
        vecs[1]  = '{1'b1, CID_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE};
        vecs[2]  = '{1'b0, CID_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000};
        vecs[3]  = '{1'b0, CID_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000};
        vecs[4]  = '{1'b0, CID_SLTU, 32'd1,          32'hFFFF_FFFF,  32'd1};
        vecs[5]  = '{1'b0, CID_SLT,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[6]  = '{1'b0, 10'h3FF,  32'h1234_5678,  32'h0000_0001,  32'hFFFF_FFFF};
        vecs[7]  = '{1'b1, CID_AND,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0};
        vecs[8]  = '{1'b1, CID_OR,   32'h1234_0000,  32'h0000_5678,  32'h1234_5678};
        vecs[9]  = '{1'b0, CID_XOR,  32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F};
        vecs[10] = '{1'b1, CID_SLL,  32'd1,          32'd31,         32'h8000_0000};
        vecs[11] = '{1'b1, CID_ADD,  32'hFFFF_FFFF,  32'd1,          32'd0};

        // Reset state.
        #1;
        check("reset ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset data", rsp_data, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        #12 nrst = 1'b1;
        tick();
        check("post reset busy", 32'(busy), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), int'(vecs[i].r), vecs[i].cid, vecs[i].a1, vecs[i].a2, vecs[i].exp);
        end

        // Contention: both requesters valid continuously for four operations.
        set_req(0, CID_ADD, 32'd1, 32'd0);
        set_req(1, CID_ADD, 32'd2, 32'd0);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int exp_w;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            exp_w = k % 2;
`else
            exp_w = 0;
`endif
            wait_ready();
            check($sformatf("cont%0d grant", k), 32'(req_ready), 32'(1) << exp_w);
            tick();
            tick();
            check($sformatf("cont%0d rsp valid", k), 32'(rsp_valid), 32'(1) << exp_w);
            check($sformatf("cont%0d rsp data", k), rsp_data, 32'(exp_w + 1));
            rsp_ready = 2'b11;
            tick();
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;
        tick();

        // Back-pressure on requester 0 while requester 1 waits and asserts a non-owner ready.
        set_req(0, CID_ADD, 32'd10, 32'd20);
        req_valid[0] = 1'b1;
        wait_ready();
        check("bp grant", 32'(req_ready), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        set_req(1, CID_SUB, 32'd9, 32'd1);
        req_valid[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d rsp valid", c), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d rsp data", c), rsp_data, 32'd30);
            check($sformatf("bp%0d ready low", c), 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check("bp release busy", 32'(busy), 32'd0);
        check("bp release rsp", 32'(rsp_valid), 32'd0);
        check("bp release ready", 32'(req_ready), 32'd2);
        req_valid[1] = 1'b0;
        tick();
        check("bp withdrawn idle", 32'(busy), 32'd0);

        // Withdraw: requester 1 pulses valid only while the block is busy.
        set_req(0, CID_ADD, 32'd100, 32'd1);
        req_valid[0] = 1'b1;
        wait_ready();
        tick();
        req_valid[0] = 1'b0;
        set_req(1, CID_ADD, 32'd7, 32'd7);
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        check("wd rsp owner", 32'(rsp_valid), 32'd1);
        check("wd rsp data", rsp_data, 32'd101);
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("wd%0d busy", c), 32'(busy), 32'd0);
            check($sformatf("wd%0d rsp", c), 32'(rsp_valid), 32'd0);
            check($sformatf("wd%0d ready", c), 32'(req_ready), 32'd0);
            tick();
        end

        // Reset asserted while a response is pending.
        set_req(1, CID_SUB, 32'd9, 32'd4);
        req_valid[1] = 1'b1;
        wait_ready();
        tick();
        req_valid[1] = 1'b0;
        tick();
        check("rst pre rsp", 32'(rsp_valid), 32'd2);
        check("rst pre data", rsp_data, 32'd5);
        #3 nrst = 1'b0;
        #1;
        check("rst mid rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst mid ready", 32'(req_ready), 32'd0);
        check("rst mid data", rsp_data, 32'd0);
        check("rst mid busy", 32'(busy), 32'd0);
        tick();
        nrst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rst after%0d busy", c), 32'(busy), 32'd0);
            check($sformatf("rst after%0d rsp", c), 32'(rsp_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
